booth_multiplier_fp32: RTL and testbench



---
 rtl/booth_multiplier_fp32.sv | 177 +++++++++++++++++
 tb/tb_booth_multiplier_fp32.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier_fp32.sv
// rtl/booth_multiplier_fp32.sv - sequential FP32 multiplier, radix-4 Booth, one partial product per cycle
module booth_multiplier_fp32 #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  // 26-bit zero-extended multiplier significand needs ceil(26/2) radix-4 digits
  localparam int ITERS = 13;

  typedef enum logic [1:0] {IDLE, ITER, NORM, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [3:0]         cnt;
  logic [23:0]        mcand;
  logic [26:0]        mplier;      // {2'b00, significand, m[-1]=0}
  logic signed [49:0] acc;
  logic signed [9:0]  exp_sum;     // ea + eb - 127
  logic               sign;
  logic               special;
  logic [31:0]        special_val;

  // operand classification at the accepting edge
  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, op_sign;
  logic        special_nxt;
  logic [31:0] special_val_nxt;

  // Booth recoding and partial product
  logic [2:0]         triplet;
  logic [4:0]         shamt;
  logic signed [49:0] mcand_ext;
  logic signed [49:0] pp_sel;
  logic signed [49:0] pp_shift;

  // normalise / round / pack
  logic [47:0]        p;
  logic               p_hi;
  logic [22:0]        mant_raw;
  logic               guard;
  logic               sticky;
  logic               round_up;
  logic [23:0]        mant_sum;
  logic [22:0]        mant_fin;
  logic signed [9:0]  exp_n;
  logic [31:0]        norm_result;

  // classify operands; subnormals are flushed to zero, specials bypass the datapath
  always_comb begin
    a_zero          = (a[30:23] == 8'd0);
    b_zero          = (b[30:23] == 8'd0);
    a_inf           = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf           = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan           = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan           = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    op_sign         = a[31] ^ b[31];
    special_nxt     = 1'b1;
    special_val_nxt = QNAN;
    if (a_nan || b_nan) begin
      special_val_nxt = QNAN;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      special_val_nxt = QNAN;
    end else if (a_inf || b_inf) begin
      special_val_nxt = {op_sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      special_val_nxt = {op_sign, 31'd0};
    end else begin
      special_nxt     = 1'b0;
    end
  end

  // recode {m[2i+1], m[2i], m[2i-1]} into a digit in {-2..+2} and weight it by 4^i
  always_comb begin
    shamt     = {cnt, 1'b0};
    triplet   = mplier[shamt +: 3];
    mcand_ext = $signed({26'd0, mcand});
    pp_sel    = '0;
    case (triplet)
      3'b001, 3'b010: pp_sel = mcand_ext;
      3'b011:         pp_sel = mcand_ext <<< 1;
      3'b100:         pp_sel = -(mcand_ext <<< 1);
      3'b101, 3'b110: pp_sel = -mcand_ext;
      default:        pp_sel = '0;
    endcase
    pp_shift  = pp_sel <<< shamt;
  end

  // significand product in [1,4): pick the window, round to nearest even, range-check the exponent
  always_comb begin
    p    = acc[47:0];
    p_hi = p[47];
    if (p_hi) begin
      mant_raw = p[46:24];
      guard    = p[23];
      sticky   = |p[22:0];
    end else begin
      mant_raw = p[45:23];
      guard    = p[22];
      sticky   = |p[21:0];
    end
    round_up = guard & (sticky | mant_raw[0]);
    mant_sum = {1'b0, mant_raw} + {23'd0, round_up};
    mant_fin = mant_sum[23] ? 23'd0 : mant_sum[22:0];
    exp_n    = exp_sum + $signed({9'd0, p_hi}) + $signed({9'd0, mant_sum[23]});
    if (special) begin
      norm_result = special_val;
    end else if (exp_n >= 10'sd255) begin
      norm_result = {sign, 8'hFF, 23'd0};
    end else if (exp_n <= 10'sd0) begin
      norm_result = {sign, 31'd0};
    end else begin
      norm_result = {sign, exp_n[7:0], mant_fin};
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // next-state and status outputs; start is only honoured in IDLE
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: if (start) state_nxt = ITER;
      ITER: if (cnt == 4'(ITERS - 1)) state_nxt = NORM;
      NORM: state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // datapath: capture operands, accumulate partial products, register the packed result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      exp_sum     <= '0;
      sign        <= 1'b0;
      special     <= 1'b0;
      special_val <= '0;
      product     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand       <= {1'b1, a[22:0]};
          mplier      <= {2'b00, 1'b1, b[22:0], 1'b0};
          acc         <= '0;
          cnt         <= '0;
          sign        <= op_sign;
          exp_sum     <= $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
          special     <= special_nxt;
          special_val <= special_val_nxt;
        end
        ITER: begin
          acc <= acc + pp_shift;
          cnt <= cnt + 4'd1;
        end
        NORM: product <= norm_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier_fp32.sv
// tb/tb_booth_multiplier_fp32.sv - scoreboard bench for booth_multiplier_fp32
module tb_booth_multiplier_fp32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;

  booth_multiplier_fp32 dut (
    .clk(clk), .rst(rst), .start(start), .a(a_in), .b(b_in),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  int          last_acc = 0;
  bit          acc_valid = 1'b0;
  logic [31:0] last_good = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference: exact integer product of significands, remainder-based round-to-nearest-even
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int ex, ey, e, sh;
    logic s;
    bit xz, yz, xi, yi, xn, yn;
    longint unsigned px, py, pr, m, rem, half;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    if (xn || yn) return 32'h7FC00000;
    if ((xi && yz) || (yi && xz)) return 32'h7FC00000;
    if (xi || yi) return {s, 8'hFF, 23'h0};
    if (xz || yz) return {s, 31'h0};
    px = {40'd0, 1'b1, x[22:0]};
    py = {40'd0, 1'b1, y[22:0]};
    pr = px * py;
    e  = ex + ey - 127;
    if (pr >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    m    = pr >> sh;
    rem  = pr & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && m[0])) m = m + 64'd1;
    if (m == (64'd1 << 24)) begin
      m = 64'd1 << 23;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] sp [8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                            32'h7FC00001, 32'h00000001, 32'h7F7FFFFF, 32'h00800000};
    logic [31:0] r;
    int mode;
    r    = $urandom;
    mode = $urandom_range(0, 3);
    case (mode)
      0: return r;
      1: return {r[31], 8'($urandom_range(100, 154)), r[22:0]};
      2: return {r[31], ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 12)) : 8'($urandom_range(120, 254)), r[22:0]};
      default: return sp[$urandom_range(0, 7)];
    endcase
  endfunction

  // monitor: timing of busy/done from the last accepted request, result popped on done, hold otherwise
  always @(negedge clk) begin
    int d;
    logic [31:0] e;
    if (rst) begin
      d = cyc - last_acc;
      check("busy", {31'd0, busy}, {31'd0, acc_valid && d >= 0 && d <= 14});
      check("done", {31'd0, done}, {31'd0, acc_valid && d == 14});
      if (done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL done_unexpected: got product %08h expected no done pulse", product);
        end else begin
          e = exp_q.pop_front();
          check("product", product, e);
          last_good = e;
        end
      end else begin
        check("product_hold", product, last_good);
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0 within 100 cycles");
    end
  endtask

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
    wait_idle();
    a_in  = x;
    b_in  = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back(e);
    last_acc  = cyc;
    acc_valid = 1'b1;
    a_in = $urandom;
    b_in = $urandom;
  endtask

  initial begin
    logic [31:0] x, y;
    int t;

    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_product", product, 32'd0);
    rst = 1'b1;

    issue(32'h40400000, 32'h40000000, 32'h40C00000);
    issue(32'h3FC00000, 32'h3FC00000, 32'h40100000);
    issue(32'hC0000000, 32'h3F000000, 32'hBF800000);
    issue(32'h3F800001, 32'h3F800001, 32'h3F800002);
    issue(32'h7F000000, 32'h7F000000, 32'h7F800000);
    issue(32'h00800000, 32'h00800000, 32'h00000000);
    issue(32'h7F800000, 32'h00000000, 32'h7FC00000);
    issue(32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    issue(32'h3FFFFFFF, 32'h3F800001, ref_mul(32'h3FFFFFFF, 32'h3F800001));
    issue(32'hBFFFFFFF, 32'h3FFFFFFF, ref_mul(32'hBFFFFFFF, 32'h3FFFFFFF));

    for (int i = 0; i < 60; i++) begin
      x = rand_fp();
      y = rand_fp();
      issue(x, y, ref_mul(x, y));
    end

    // start held high with operands changing every cycle: only every 16th edge accepts
    wait_idle();
    a_in  = rand_fp();
    b_in  = rand_fp();
    start = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk);
      #1;
      if (k % 16 == 0) begin
        exp_q.push_back(ref_mul(a_in, b_in));
        last_acc  = cyc;
        acc_valid = 1'b1;
      end
      a_in = rand_fp();
      b_in = rand_fp();
    end
    start = 1'b0;

    // reset in ITER cycle 6 discards the operation
    issue(32'h40A00000, 32'h40400000, 32'h41700000);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_product", product, 32'd0);
    exp_q.delete();
    acc_valid = 1'b0;
    last_good = '0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    issue(32'h40400000, 32'h40000000, 32'h40C00000);
    issue(32'hC1200000, 32'h3DCCCCCD, ref_mul(32'hC1200000, 32'h3DCCCCCD));

    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
